// File: rtl/ex_pkg.sv
// Shared types and constants for the EX-stage sequencer: FSM states,
// branch condition codes, operation commands and CPSR flag positions.
package ex_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WB,
    ST_BRANCH,
    ST_HALT
  } state_t;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [2:0] OC_B     = 3'b000;
  localparam logic [2:0] OC_BCOND = 3'b001;
  localparam logic [2:0] OC_HALT  = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition resolver: decides whether a conditional
// branch is taken given the current {N,C,Z,V} flags.
module branch_cond_eval
  import ex_pkg::*;
(
  input  logic [3:0] cpsr,
  input  logic [3:0] cond,
  output logic       taken
);

  logic n, c, z, v;

  assign n = cpsr[FLAG_N];
  assign c = cpsr[FLAG_C];
  assign z = cpsr[FLAG_Z];
  assign v = cpsr[FLAG_V];

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_MI: taken = n;
      COND_PL: taken = !n;
      COND_VS: taken = v;
      COND_VC: taken = !v;
      COND_HI: taken = c && !z;
      COND_LS: taken = !(c && !z);
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z && (n == v);
      COND_LE: taken = !(!z && (n == v));
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_sequencer.sv
// EX-stage controller: steps one instruction at a time through EXEC and
// then WB/BRANCH/HALT, owns the CPSR and arbitrates the register write port.
module ex_sequencer
  import ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3,
  parameter int OFF_W  = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [1:0]        id_first_ld,
  input  logic              id_special,
  input  logic              id_set_flags,
  input  logic [2:0]        id_alu_oc,
  input  logic [3:0]        id_b_cond,
  input  logic [REG_AW-1:0] id_dest,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [OFF_W-1:0]  id_offset,
  output logic              ex_valid,
  output logic [1:0]        ex_first_ld,
  output logic              ex_special,
  output logic [2:0]        ex_alu_oc,
  input  logic [DATA_W:0]   alu_result,
  input  logic              alu_v,
  input  logic              ld_we,
  input  logic [REG_AW-1:0] ld_waddr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        cpsr,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_target,
  output logic              ex_flush,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  state_t            state;
  logic [1:0]        first_ld_q;
  logic              special_q;
  logic              set_flags_q;
  logic [2:0]        oc_q;
  logic [3:0]        cond_q;
  logic [REG_AW-1:0] dest_q;
  logic [DATA_W-1:0] pc_q;
  logic [OFF_W-1:0]  offset_q;
  logic [DATA_W:0]   result_q;
  logic              v_q;
  logic [3:0]        cpsr_q;
  logic [CNT_W-1:0]  retired_q;
  logic              halted_q;
  logic              cond_taken;
  logic              br_taken;
  logic              wb_write;
  logic [DATA_W-1:0] target;

  branch_cond_eval u_cond (
    .cpsr  (cpsr_q),
    .cond  (cond_q),
    .taken (cond_taken)
  );

  assign br_taken = (oc_q == OC_B) || cond_taken;
  assign target   = pc_q + {{(DATA_W-OFF_W){offset_q[OFF_W-1]}}, offset_q};
  assign wb_write = (state == ST_WB) && !ld_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      first_ld_q  <= '0;
      special_q   <= 1'b0;
      set_flags_q <= 1'b0;
      oc_q        <= '0;
      cond_q      <= '0;
      dest_q      <= '0;
      pc_q        <= '0;
      offset_q    <= '0;
      result_q    <= '0;
      v_q         <= 1'b0;
      cpsr_q      <= '0;
      retired_q   <= '0;
      halted_q    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (id_valid && !halted_q) begin
            first_ld_q  <= id_first_ld;
            special_q   <= id_special;
            set_flags_q <= id_set_flags;
            oc_q        <= id_alu_oc;
            cond_q      <= id_b_cond;
            dest_q      <= id_dest;
            pc_q        <= id_pc;
            offset_q    <= id_offset;
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_q <= alu_result;
          v_q      <= alu_v;
          if (special_q || first_ld_q == 2'b00) begin
            state <= ST_WB;
          end else if (oc_q == OC_B || oc_q == OC_BCOND) begin
            state <= ST_BRANCH;
          end else if (oc_q == OC_HALT) begin
            halted_q  <= 1'b1;
            retired_q <= retired_q + CNT_W'(1);
            state     <= ST_HALT;
          end else begin
            retired_q <= retired_q + CNT_W'(1);
            state     <= ST_IDLE;
          end
        end
        // A pending load write owns the port; WB simply waits it out.
        ST_WB: begin
          if (!ld_we) begin
            if (special_q && set_flags_q) begin
              cpsr_q[FLAG_N] <= result_q[DATA_W-1];
              cpsr_q[FLAG_C] <= result_q[DATA_W];
              cpsr_q[FLAG_Z] <= (result_q[DATA_W-1:0] == '0);
              cpsr_q[FLAG_V] <= v_q;
            end
            retired_q <= retired_q + CNT_W'(1);
            state     <= ST_IDLE;
          end
        end
        ST_BRANCH: begin
          retired_q <= retired_q + CNT_W'(1);
          state     <= ST_IDLE;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Reset gating keeps the pass-through paths quiet while rst is held.
  always_comb begin
    rf_we    = ld_we;
    rf_waddr = ld_waddr;
    rf_wdata = ld_wdata;
    if (wb_write) begin
      rf_we    = 1'b1;
      rf_waddr = dest_q;
      rf_wdata = result_q[DATA_W-1:0];
    end
    if (rst) begin
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
    end
  end

  assign id_ready    = !rst && (state == ST_IDLE) && !halted_q;
  assign ex_valid    = (state == ST_EXEC);
  assign ex_first_ld = first_ld_q;
  assign ex_special  = special_q;
  assign ex_alu_oc   = oc_q;
  assign pc_load     = (state == ST_BRANCH) && br_taken;
  assign ex_flush    = pc_load;
  assign pc_target   = pc_load ? target : '0;
  assign cpsr        = cpsr_q;
  assign halted      = halted_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_ex_sequencer.sv
// Scoreboard bench for ex_sequencer: directed instructions push expected
// register writes and redirects; a negedge monitor pops and compares them.
module tb_ex_sequencer;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [1:0]  id_first_ld = '0;
  logic        id_special = 1'b0;
  logic        id_set_flags = 1'b0;
  logic [2:0]  id_alu_oc = '0;
  logic [3:0]  id_b_cond = '0;
  logic [2:0]  id_dest = '0;
  logic [31:0] id_pc = '0;
  logic [15:0] id_offset = '0;
  logic        ex_valid;
  logic [1:0]  ex_first_ld;
  logic        ex_special;
  logic [2:0]  ex_alu_oc;
  logic [32:0] alu_result = '0;
  logic        alu_v = 1'b0;
  logic        ld_we = 1'b0;
  logic [2:0]  ld_waddr = '0;
  logic [31:0] ld_wdata = '0;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  cpsr;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        ex_flush;
  logic        halted;
  logic [31:0] retired;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] br_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          br_pulses = 0;

  ex_sequencer dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_first_ld(id_first_ld), .id_special(id_special),
    .id_set_flags(id_set_flags), .id_alu_oc(id_alu_oc),
    .id_b_cond(id_b_cond), .id_dest(id_dest),
    .id_pc(id_pc), .id_offset(id_offset),
    .ex_valid(ex_valid), .ex_first_ld(ex_first_ld),
    .ex_special(ex_special), .ex_alu_oc(ex_alu_oc),
    .alu_result(alu_result), .alu_v(alu_v),
    .ld_we(ld_we), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .cpsr(cpsr), .pc_load(pc_load), .pc_target(pc_target),
    .ex_flush(ex_flush), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Waits (bounded) for id_ready, then presents one instruction for a cycle.
  // Returns #1 after the accepting edge, i.e. during EXEC.
  task automatic applyStimulus(input logic [1:0] fl, input logic sp, input logic sf,
                               input logic [2:0] oc, input logic [3:0] cond,
                               input logic [2:0] dest, input logic [31:0] pc,
                               input logic [15:0] off);
    int waited = 0;
    while (!id_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!id_ready) checkOutput("id_ready_timeout", 64'(id_ready), 64'(1'b1));
    id_first_ld  = fl;
    id_special   = sp;
    id_set_flags = sf;
    id_alu_oc    = oc;
    id_b_cond    = cond;
    id_dest      = dest;
    id_pc        = pc;
    id_offset    = off;
    id_valid     = 1'b1;
    @(posedge clk); #1;
    id_valid = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rf_we) begin
        if (wr_q.size() == 0) begin
          checkOutput("unexpected_rf_write", 64'(rf_waddr), 64'hFFFF);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          checkOutput("rf_waddr", 64'(rf_waddr), 64'(e.addr));
          checkOutput("rf_wdata", 64'(rf_wdata), 64'(e.data));
        end
      end
      if (pc_load || ex_flush) begin
        br_pulses++;
        checkOutput("flush_with_load", 64'({pc_load, ex_flush}), 64'(2'b11));
        if (br_q.size() == 0) begin
          checkOutput("unexpected_redirect", 64'(pc_target), 64'hFFFF_FFFF_FFFF);
        end else begin
          checkOutput("pc_target", 64'(pc_target), 64'(br_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pulses_before;
    #12;
    checkOutput("rst_id_ready", 64'(id_ready), 64'(1'b0));
    checkOutput("rst_cpsr", 64'(cpsr), 64'(4'b0000));
    checkOutput("rst_retired", 64'(retired), 64'(32'd0));
    checkOutput("rst_halted", 64'(halted), 64'(1'b0));
    checkOutput("rst_rf_we", 64'(rf_we), 64'(1'b0));
    checkOutput("rst_pc_load", 64'(pc_load), 64'(1'b0));
    @(posedge clk); #1;
    rst = 1'b0;
    nextCycle();
    checkOutput("idle_ready", 64'(id_ready), 64'(1'b1));

    // ALU add with flags: 5 + 0xFFFFFFFB = 0x1_0000_0000 -> C=1, Z=1.
    applyStimulus(2'b00, 1'b1, 1'b1, 3'b000, 4'h0, 3'd2, 32'h0, 16'h0);
    checkOutput("exec_valid", 64'(ex_valid), 64'(1'b1));
    checkOutput("exec_special", 64'(ex_special), 64'(1'b1));
    alu_result = 33'h1_0000_0000;
    alu_v = 1'b0;
    wr_q.push_back('{3'd2, 32'h0});
    nextCycle();
    nextCycle();
    checkOutput("add_cpsr", 64'(cpsr), 64'(4'b0110));
    checkOutput("add_retired", 64'(retired), 64'(32'd1));
    checkOutput("add_ready", 64'(id_ready), 64'(1'b1));

    // EQ branch with Z=1: taken, 0x100 + 0xFFFFFFF0 = 0xF0.
    pulses_before = br_pulses;
    br_q.push_back(32'h0000_00F0);
    applyStimulus(2'b10, 1'b0, 1'b0, OC_BCOND, COND_EQ, 3'd0, 32'h100, 16'hFFF0);
    nextCycle();
    nextCycle();
    checkOutput("eq_pulses", 64'(br_pulses - pulses_before), 64'd1);
    checkOutput("eq_retired", 64'(retired), 64'(32'd2));
    checkOutput("eq_ready", 64'(id_ready), 64'(1'b1));

    // NE branch with Z=1: not taken.
    pulses_before = br_pulses;
    applyStimulus(2'b10, 1'b0, 1'b0, OC_BCOND, COND_NE, 3'd0, 32'h300, 16'h0040);
    nextCycle();
    nextCycle();
    checkOutput("ne_pulses", 64'(br_pulses - pulses_before), 64'd0);
    checkOutput("ne_retired", 64'(retired), 64'(32'd3));
    checkOutput("ne_ready", 64'(id_ready), 64'(1'b1));

    // Unconditional branch ignores the NV condition code.
    br_q.push_back(32'h0000_1010);
    applyStimulus(2'b01, 1'b0, 1'b0, OC_B, COND_NV, 3'd0, 32'h1000, 16'h0010);
    nextCycle();
    nextCycle();
    checkOutput("b_retired", 64'(retired), 64'(32'd4));

    // MOV with set_flags asserted: writes, but flags stay untouched.
    applyStimulus(2'b00, 1'b0, 1'b1, 3'b010, 4'h0, 3'd5, 32'h0, 16'h0);
    alu_result = 33'h0_8000_0000;
    wr_q.push_back('{3'd5, 32'h8000_0000});
    nextCycle();
    nextCycle();
    checkOutput("mov_cpsr", 64'(cpsr), 64'(4'b0110));
    checkOutput("mov_retired", 64'(retired), 64'(32'd5));

    // ALU without set_flags: carry bit dropped from the write data.
    applyStimulus(2'b00, 1'b1, 1'b0, 3'b011, 4'h0, 3'd3, 32'h0, 16'h0);
    alu_result = 33'h1_2345_6789;
    wr_q.push_back('{3'd3, 32'h2345_6789});
    nextCycle();
    nextCycle();
    checkOutput("nf_cpsr", 64'(cpsr), 64'(4'b0110));

    // Load unit holds the port for two WB cycles; EX write follows.
    applyStimulus(2'b00, 1'b1, 1'b1, 3'b000, 4'h0, 3'd7, 32'h0, 16'h0);
    alu_result = 33'h0_8000_0001;
    alu_v = 1'b1;
    wr_q.push_back('{3'd1, 32'hAAAA_0001});
    wr_q.push_back('{3'd4, 32'hBBBB_0002});
    wr_q.push_back('{3'd7, 32'h8000_0001});
    nextCycle();
    ld_we = 1'b1; ld_waddr = 3'd1; ld_wdata = 32'hAAAA_0001;
    nextCycle();
    ld_waddr = 3'd4; ld_wdata = 32'hBBBB_0002;
    checkOutput("stall_cpsr", 64'(cpsr), 64'(4'b0110));
    nextCycle();
    ld_we = 1'b0; ld_waddr = 3'd0; ld_wdata = 32'h0;
    checkOutput("stall_retired", 64'(retired), 64'(32'd6));
    nextCycle();
    checkOutput("conflict_cpsr", 64'(cpsr), 64'(4'b1001));
    checkOutput("conflict_retired", 64'(retired), 64'(32'd7));
    alu_v = 1'b0;

    // GE with N=V=1: taken; negative offset sign-extends.
    br_q.push_back(32'hFFFF_8200);
    applyStimulus(2'b10, 1'b0, 1'b0, OC_BCOND, COND_GE, 3'd0, 32'h200, 16'h8000);
    nextCycle();
    nextCycle();

    // LT with N==V: not taken.
    pulses_before = br_pulses;
    applyStimulus(2'b10, 1'b0, 1'b0, OC_BCOND, COND_LT, 3'd0, 32'h400, 16'h0004);
    nextCycle();
    nextCycle();
    checkOutput("lt_pulses", 64'(br_pulses - pulses_before), 64'd0);

    // Unused op command: NOP returns to IDLE straight from EXEC.
    applyStimulus(2'b01, 1'b0, 1'b0, 3'b010, 4'h0, 3'd6, 32'h0, 16'h0);
    nextCycle();
    checkOutput("nop_retired", 64'(retired), 64'(32'd10));
    checkOutput("nop_ready", 64'(id_ready), 64'(1'b1));

    // Reset during EXEC: the instruction vanishes, nothing is written.
    applyStimulus(2'b00, 1'b1, 1'b1, 3'b000, 4'h0, 3'd6, 32'h0, 16'h0);
    alu_result = 33'h0_0000_0042;
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_ex_valid", 64'(ex_valid), 64'(1'b0));
    checkOutput("mid_rst_ready", 64'(id_ready), 64'(1'b0));
    checkOutput("mid_rst_cpsr", 64'(cpsr), 64'(4'b0000));
    checkOutput("mid_rst_retired", 64'(retired), 64'(32'd0));
    nextCycle();
    rst = 1'b0;
    nextCycle();
    checkOutput("post_rst_ready", 64'(id_ready), 64'(1'b1));
    nextCycle();
    checkOutput("post_rst_retired", 64'(retired), 64'(32'd0));

    // HALT is sticky; the write port still passes load traffic through.
    applyStimulus(2'b11, 1'b0, 1'b0, OC_HALT, 4'h0, 3'd0, 32'h0, 16'h0);
    nextCycle();
    id_valid = 1'b1;
    for (int i = 0; i < 4; i++) nextCycle();
    checkOutput("halt_halted", 64'(halted), 64'(1'b1));
    checkOutput("halt_ready", 64'(id_ready), 64'(1'b0));
    checkOutput("halt_retired", 64'(retired), 64'(32'd1));
    wr_q.push_back('{3'd2, 32'h1234_5678});
    ld_we = 1'b1; ld_waddr = 3'd2; ld_wdata = 32'h1234_5678;
    nextCycle();
    ld_we = 1'b0;
    id_valid = 1'b0;
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    nextCycle();
    checkOutput("unhalt_halted", 64'(halted), 64'(1'b0));
    checkOutput("unhalt_ready", 64'(id_ready), 64'(1'b1));

    checkOutput("wr_q_drained", 64'(wr_q.size()), 64'd0);
    checkOutput("br_q_drained", 64'(br_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
